// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: arbitration states, read-owner tags,
// and the CPU opcode constants used by the MEM stage that drives the CPU port.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        CPU_PRI     = 2'd0,
        HOST_PRI    = 2'd1,
        HOST_LOCKED = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } owner_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    function automatic logic addr_in_range(input logic [31:0] addr, input int depth);
        return addr < 32'(depth);
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port arbiter (CPU MEM stage / host loader) in front of a single-port
// synchronous data RAM with one-cycle read latency.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// CPU_PRI     | CPU wins contention; host counts starved cycles
// HOST_PRI    | host starved too long; host wins its next access only
// HOST_LOCKED | host burst in progress; CPU stalled until host_lock drops
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int REG_WIDTH    = 32,
    parameter int DEPTH        = 300,
    parameter int ADDR_W       = 9,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 CLOCK_50,
    input  logic                 rstn,

    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic [REG_WIDTH-1:0] cpu_wdata,
    output logic                 cpu_gnt,
    output logic                 cpu_rvalid,
    output logic [REG_WIDTH-1:0] cpu_rdata,

    input  logic                 host_req,
    input  logic                 host_we,
    input  logic                 host_lock,
    input  logic [ADDR_W-1:0]    host_addr,
    input  logic [REG_WIDTH-1:0] host_wdata,
    output logic                 host_gnt,
    output logic                 host_rvalid,
    output logic [REG_WIDTH-1:0] host_rdata,

    output logic                 mem_wr_en,
    output logic [ADDR_W-1:0]    mem_index,
    output logic [REG_WIDTH-1:0] mem_entry,
    input  logic [REG_WIDTH-1:0] mem_entry_out,

    output logic                 addr_err
);

    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e           state_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    owner_e               owner_q;
    logic                 oor_q;
    logic [ADDR_W-1:0]    idx_q;
    logic [REG_WIDTH-1:0] cpu_rdata_q, host_rdata_q;
    logic                 cpu_oor, host_oor;

    assign cpu_oor  = !addr_in_range(32'(cpu_addr), DEPTH);
    assign host_oor = !addr_in_range(32'(host_addr), DEPTH);

    // Grants are gated by rstn so reset silences the RAM port immediately.
    always_comb begin
        cpu_gnt  = 1'b0;
        host_gnt = 1'b0;
        if (rstn) begin
            case (state_q)
                CPU_PRI: begin
                    cpu_gnt  = cpu_req;
                    host_gnt = host_req & ~cpu_req;
                end
                HOST_PRI: begin
                    host_gnt = host_req;
                    cpu_gnt  = cpu_req & ~host_req;
                end
                HOST_LOCKED: begin
                    host_gnt = host_req;
                end
                default: begin
                    cpu_gnt  = 1'b0;
                    host_gnt = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!host_req || host_gnt) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign mem_index = cpu_gnt  ? cpu_addr  :
                       host_gnt ? host_addr : idx_q;
    assign mem_entry = host_gnt ? host_wdata : cpu_wdata;
    assign mem_wr_en = (cpu_gnt  & cpu_we  & ~cpu_oor) |
                       (host_gnt & host_we & ~host_oor);
    assign addr_err  = (cpu_gnt & cpu_oor) | (host_gnt & host_oor);

    // Read data is only live in the return cycle; otherwise replay the last value.
    assign cpu_rvalid  = (owner_q == OWN_CPU);
    assign host_rvalid = (owner_q == OWN_HOST);
    assign cpu_rdata   = cpu_rvalid  ? (oor_q ? '0 : mem_entry_out) : cpu_rdata_q;
    assign host_rdata  = host_rvalid ? (oor_q ? '0 : mem_entry_out) : host_rdata_q;

    always_ff @(posedge CLOCK_50 or negedge rstn) begin
        if (!rstn) begin
            state_q      <= CPU_PRI;
            cnt_q        <= '0;
            owner_q      <= OWN_NONE;
            oor_q        <= 1'b0;
            idx_q        <= '0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            cnt_q <= cnt_d;

            case (state_q)
                CPU_PRI: begin
                    if (host_gnt && host_lock) begin
                        state_q <= HOST_LOCKED;
                    end else if (cnt_d == CNT_MAX) begin
                        state_q <= HOST_PRI;
                    end
                end
                HOST_PRI: begin
                    if (host_gnt && host_lock) begin
                        state_q <= HOST_LOCKED;
                    end else if (host_gnt || !host_req) begin
                        state_q <= CPU_PRI;
                    end
                end
                HOST_LOCKED: begin
                    if (!host_lock) begin
                        state_q <= CPU_PRI;
                    end
                end
                default: begin
                    state_q <= CPU_PRI;
                end
            endcase

            if (cpu_gnt) begin
                idx_q <= cpu_addr;
            end else if (host_gnt) begin
                idx_q <= host_addr;
            end

            owner_q <= OWN_NONE;
            oor_q   <= 1'b0;
            if (cpu_gnt && !cpu_we) begin
                owner_q <= OWN_CPU;
                oor_q   <= cpu_oor;
            end else if (host_gnt && !host_we) begin
                owner_q <= OWN_HOST;
                oor_q   <= host_oor;
            end

            if (cpu_rvalid) begin
                cpu_rdata_q <= cpu_rdata;
            end
            if (host_rvalid) begin
                host_rdata_q <= host_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural RAM, shadow memory for
// expected read data, and per-port scoreboard queues drained on rvalid.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int RW    = 32;
    localparam int DEPTH = 300;
    localparam int AW    = 9;

    logic          CLOCK_50 = 1'b0;
    logic          rstn;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [RW-1:0] cpu_wdata, cpu_rdata;
    logic          host_req, host_we, host_lock, host_gnt, host_rvalid;
    logic [AW-1:0] host_addr;
    logic [RW-1:0] host_wdata, host_rdata;
    logic          mem_wr_en, addr_err;
    logic [AW-1:0] mem_index;
    logic [RW-1:0] mem_entry, mem_entry_out;

    logic [RW-1:0] ram    [DEPTH];
    logic [RW-1:0] shadow [DEPTH];
    logic [RW-1:0] cpu_exp_q[$];
    logic [RW-1:0] host_exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;

    dmem_arbiter #(
        .REG_WIDTH(RW), .DEPTH(DEPTH), .ADDR_W(AW), .STARVE_LIMIT(4)
    ) dut (
        .CLOCK_50(CLOCK_50), .rstn(rstn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_lock(host_lock),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_wr_en(mem_wr_en), .mem_index(mem_index), .mem_entry(mem_entry),
        .mem_entry_out(mem_entry_out), .addr_err(addr_err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] <= 32'h1000_0000 + 32'(i);
        ram[10] <= 32'd7;
        ram[11] <= 32'd9;
    end

    always @(posedge CLOCK_50) begin
        if (mem_wr_en && int'(mem_index) < DEPTH) ram[mem_index] <= mem_entry;
        mem_entry_out <= (int'(mem_index) < DEPTH) ? ram[mem_index] : 32'hFFFF_FFFF;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, expv);
        end
    endtask

    function automatic logic [RW-1:0] exp_rd(input logic [AW-1:0] a);
        if (int'(a) < DEPTH) return shadow[a];
        return '0;
    endfunction

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic cpu_drv(input logic req, input logic we, input logic [AW-1:0] a,
                           input logic [RW-1:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic host_drv(input logic req, input logic we, input logic lock,
                            input logic [AW-1:0] a, input logic [RW-1:0] d);
        host_req = req; host_we = we; host_lock = lock; host_addr = a; host_wdata = d;
    endtask

    always @(negedge CLOCK_50) begin
        check("gnt_onehot", 32'(cpu_gnt & host_gnt), 32'd0);
        if (cpu_rvalid) begin
            if (cpu_exp_q.size() == 0) check("cpu_rvalid_unexpected", 32'(cpu_rvalid), 32'd0);
            else check("cpu_rdata", cpu_rdata, cpu_exp_q.pop_front());
        end
        if (host_rvalid) begin
            if (host_exp_q.size() == 0) check("host_rvalid_unexpected", 32'(host_rvalid), 32'd0);
            else check("host_rdata", host_rdata, host_exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_h;
        logic [AW-1:0] ha;
        for (int i = 0; i < DEPTH; i++) shadow[i] = 32'h1000_0000 + 32'(i);
        shadow[10] = 32'd7;
        shadow[11] = 32'd9;

        rstn = 1'b0;
        cpu_drv(1'b0, 1'b0, '0, '0);
        host_drv(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge CLOCK_50);
        check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        check("rst_host_gnt", 32'(host_gnt), 32'd0);
        check("rst_rvalid", 32'({cpu_rvalid, host_rvalid}), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_host_rdata", host_rdata, 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(CPU_PRI));

        // First grant right after release, then alternating-owner reads.
        step();
        rstn = 1'b1;
        cpu_drv(1'b1, 1'b0, AW'(10), '0);
        @(negedge CLOCK_50);
        check("first_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check("first_host_gnt", 32'(host_gnt), 32'd0);
        cpu_exp_q.push_back(exp_rd(AW'(10)));
        step();
        cpu_drv(1'b0, 1'b0, '0, '0);
        host_drv(1'b1, 1'b0, 1'b0, AW'(11), '0);
        @(negedge CLOCK_50);
        check("alt_host_gnt", 32'(host_gnt), 32'd1);
        check("alt_cpu_rdata_c2", cpu_rdata, 32'd7);
        check("alt_cpu_rvalid_c2", 32'(cpu_rvalid), 32'd1);
        host_exp_q.push_back(exp_rd(AW'(11)));
        step();
        host_drv(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge CLOCK_50);
        check("alt_host_rdata_c3", host_rdata, 32'd9);
        check("alt_cpu_rdata_hold", cpu_rdata, 32'd7);
        check("alt_cpu_rvalid_c3", 32'(cpu_rvalid), 32'd0);

        // Reset in the return cycle of a host read.
        step();
        host_drv(1'b1, 1'b0, 1'b0, AW'(5), '0);
        @(negedge CLOCK_50);
        check("midrd_host_gnt", 32'(host_gnt), 32'd1);
        @(posedge CLOCK_50);
        #1;
        rstn = 1'b0;
        host_drv(1'b0, 1'b0, 1'b0, '0, '0);
        cpu_drv(1'b1, 1'b1, AW'(20), 32'h5555_5555);
        #1;
        check("midrd_host_rvalid", 32'(host_rvalid), 32'd0);
        check("midrd_host_rdata", host_rdata, 32'd0);
        check("midrd_cpu_rdata", cpu_rdata, 32'd0);
        check("midrd_state", 32'(dut.state_q), 32'(CPU_PRI));
        check("midrd_cpu_gnt", 32'(cpu_gnt), 32'd0);
        check("midrd_wr_en", 32'(mem_wr_en), 32'd0);
        step();
        cpu_drv(1'b0, 1'b0, '0, '0);
        rstn = 1'b1;
        @(negedge CLOCK_50);
        check("midrd_host_rdata_after", host_rdata, 32'd0);

        // Continuous contention: 4 CPU grants then 1 host grant, repeating.
        step();
        for (int k = 0; k < 15; k++) begin
            ha = AW'(100 + k / 5);
            cpu_drv(1'b1, 1'b0, AW'(20 + k), '0);
            host_drv(1'b1, 1'b0, 1'b0, ha, '0);
            exp_h = (k % 5 == 4);
            @(negedge CLOCK_50);
            check($sformatf("cont%0d_cpu_gnt", k), 32'(cpu_gnt), 32'(!exp_h));
            check($sformatf("cont%0d_host_gnt", k), 32'(host_gnt), 32'(exp_h));
            if (exp_h) host_exp_q.push_back(exp_rd(ha));
            else cpu_exp_q.push_back(exp_rd(AW'(20 + k)));
            step();
        end
        cpu_drv(1'b0, 1'b0, '0, '0);
        host_drv(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge CLOCK_50);
        step();

        // Locked host preload of 297..299; CPU read of 299 waits it out.
        for (int w = 0; w < 3; w++) begin
            host_drv(1'b1, 1'b1, 1'b1, AW'(297 + w), 32'hA5A5_0003 - 32'(w));
            if (w > 0) cpu_drv(1'b1, 1'b0, AW'(299), '0);
            @(negedge CLOCK_50);
            check($sformatf("lock%0d_host_gnt", w), 32'(host_gnt), 32'd1);
            check($sformatf("lock%0d_cpu_gnt", w), 32'(cpu_gnt), 32'd0);
            check($sformatf("lock%0d_wr_en", w), 32'(mem_wr_en), 32'd1);
            shadow[297 + w] = 32'hA5A5_0003 - 32'(w);
            step();
        end
        host_drv(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge CLOCK_50);
        check("lock_release_cpu_gnt", 32'(cpu_gnt), 32'd0);
        step();
        @(negedge CLOCK_50);
        check("preload_cpu_gnt", 32'(cpu_gnt), 32'd1);
        cpu_exp_q.push_back(exp_rd(AW'(299)));
        step();
        cpu_drv(1'b0, 1'b0, '0, '0);
        @(negedge CLOCK_50);
        check("preload_rdata", cpu_rdata, 32'hA5A5_0001);
        check("preload_rvalid", 32'(cpu_rvalid), 32'd1);

        // In-range CPU write then read back.
        step();
        cpu_drv(1'b1, 1'b1, AW'(50), 32'h1234_5678);
        @(negedge CLOCK_50);
        check("cpu_wr_en", 32'(mem_wr_en), 32'd1);
        check("cpu_wr_index", 32'(mem_index), 32'd50);
        check("cpu_wr_entry", mem_entry, 32'h1234_5678);
        shadow[50] = 32'h1234_5678;
        step();
        cpu_drv(1'b1, 1'b0, AW'(50), '0);
        @(negedge CLOCK_50);
        cpu_exp_q.push_back(exp_rd(AW'(50)));
        step();

        // Out-of-range write and read.
        cpu_drv(1'b1, 1'b1, AW'(300), 32'hDEAD_BEEF);
        @(negedge CLOCK_50);
        check("oor_wr_gnt", 32'(cpu_gnt), 32'd1);
        check("oor_wr_en", 32'(mem_wr_en), 32'd0);
        check("oor_wr_err", 32'(addr_err), 32'd1);
        step();
        cpu_drv(1'b0, 1'b0, '0, '0);
        @(negedge CLOCK_50);
        check("oor_err_pulse", 32'(addr_err), 32'd0);
        step();
        cpu_drv(1'b1, 1'b0, AW'(300), '0);
        @(negedge CLOCK_50);
        check("oor_rd_err", 32'(addr_err), 32'd1);
        cpu_exp_q.push_back(exp_rd(AW'(300)));
        step();
        cpu_drv(1'b0, 1'b0, '0, '0);
        @(negedge CLOCK_50);
        check("oor_rd_rvalid", 32'(cpu_rvalid), 32'd1);
        check("oor_rd_rdata", cpu_rdata, 32'd0);
        check("idle_index_hold", 32'(mem_index), 32'd300);
        check("idle_wr_en", 32'(mem_wr_en), 32'd0);
        step();
        step();

        check("cpu_queue_drained", 32'(cpu_exp_q.size()), 32'd0);
        check("host_queue_drained", 32'(host_exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, data word width.
REQ-002 SHALL have parameter DEPTH, default 300 (M*N+N*N2+M*N2 for 10x10x10), data-memory words.
REQ-003 SHALL have parameter ADDR_W, default 9, word-index width.
REQ-004 SHALL have parameter STARVE_LIMIT, default 4, maximum consecutive host-waiting cycles.
REQ-005 SHALL have port CLOCK_50, input, 1, the single clock.
REQ-006 SHALL have port rstn, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have ports cpu_req, cpu_we (input, 1), cpu_addr (input, ADDR_W), cpu_wdata (input, REG_WIDTH): pipeline MEM-stage access.
REQ-008 SHALL have ports cpu_gnt, cpu_rvalid (output, 1), cpu_rdata (output, REG_WIDTH): CPU grant and read return.
REQ-009 SHALL have ports host_req, host_we, host_lock (input, 1), host_addr (input, ADDR_W), host_wdata (input, REG_WIDTH): loader/readback port.
REQ-010 SHALL have ports host_gnt, host_rvalid (output, 1), host_rdata (output, REG_WIDTH).
REQ-011 SHALL have ports mem_wr_en (output, 1), mem_index (output, ADDR_W), mem_entry (output, REG_WIDTH), mem_entry_out (input, REG_WIDTH): single-port synchronous RAM, one-cycle read latency.
REQ-012 SHALL have port addr_err, output, 1: one-cycle pulse on an out-of-range granted access.

Function
REQ-013 Grant SHALL be combinational from the current FSM state and requests; at most one of cpu_gnt/host_gnt SHALL be high per cycle.
REQ-014 A request SHALL complete in the cycle its grant is high; an ungranted requester SHALL hold req/we/addr/wdata stable until granted.
REQ-015 The FSM SHALL have states CPU_PRI, HOST_PRI and HOST_LOCKED; reset state CPU_PRI.
REQ-016 In CPU_PRI: cpu_req wins; host is granted only when cpu_req is low.
REQ-017 Starvation counter SHALL increment each cycle host_req is high and ungranted, clear on host grant or host_req low, and saturate at STARVE_LIMIT.
REQ-018 When the counter reaches STARVE_LIMIT, the FSM SHALL move to HOST_PRI; in HOST_PRI host wins for exactly one granted access, then the FSM returns to CPU_PRI.
REQ-019 A host grant with host_lock high SHALL move the FSM to HOST_LOCKED; there host is the only grantee (CPU stalls) until a cycle with host_lock low, then CPU_PRI.
REQ-020 mem_index, mem_entry and mem_wr_en SHALL mux from the granted port; mem_wr_en SHALL be high only for a granted in-range write.
REQ-021 A granted read SHALL register an owner tag; in the next cycle the owner's rvalid SHALL be 1 and its rdata SHALL equal mem_entry_out; the other port's rdata SHALL hold its last value.
REQ-022 Back-to-back reads from alternating owners SHALL each return to the correct owner, one per cycle, with no bubble.
REQ-023 An address >= DEPTH SHALL suppress the write, return rdata 0 with rvalid on a read, and pulse addr_err in the grant cycle.
REQ-024 With no grant, mem_wr_en SHALL be 0 and mem_index SHALL hold its last value.

Reset
REQ-025 Reset assertion SHALL immediately force state CPU_PRI, counter 0, both gnt and rvalid 0, both rdata 0, addr_err 0 and mem_wr_en 0; an in-flight read return SHALL be discarded.
REQ-026 The first grant SHALL be possible in the first rising edge cycle after rstn deasserts.

Structure
REQ-027 The FSM state enum and the owner-tag encoding SHALL live in a shared package with the CPU opcode constants.
REQ-028 The block SHALL contain no sub-module; the RAM stays instantiated outside, in the CPU top.

Verification
REQ-029 Reset mid-read: host read of addr 5 granted, rstn low the next cycle -> host_rvalid 0, host_rdata 0, state CPU_PRI.
REQ-030 Contention: cpu_req and host_req held high continuously -> CPU is granted 4 cycles, host is granted the 5th, and the pattern repeats.
REQ-031 Preload: host writes 0xA5A5_0001 to index 299 with host_lock high for 3 writes -> cpu_gnt 0 throughout; a later CPU read of 299 returns 0xA5A5_0001 one cycle after grant.
REQ-032 Alternating reads: CPU read idx 10 then host read idx 11 in consecutive cycles (RAM 10=7, 11=9) -> cpu_rdata 7 in cycle 2, host_rdata 9 in cycle 3.
REQ-033 Out-of-range: CPU write to idx 300 -> mem_wr_en 0, addr_err 1 for one cycle; a read of idx 300 returns 0 with cpu_rvalid 1.
